// File: rtl/qmac_accum.sv
// Multiply-accumulate back end: sums a burst of sign-magnitude Q products with per-step
// saturation and presents the result through a valid/ready handshake.
module qmac_accum #(
    parameter int unsigned Q     = 15,
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_product,
    input  logic             i_ovr,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_result,
    output logic             o_ovr,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned AW = N + 1;
    localparam int unsigned MW = N - 1;
    localparam logic signed [AW-1:0] MAX_POS = {2'b00, {MW{1'b1}}};
    localparam logic signed [AW-1:0] MAX_NEG = -MAX_POS;

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e                 state_q;
    logic signed [AW-1:0]   acc_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovr_q;

    logic                   beat;
    logic signed [AW-1:0]   prod_mag;
    logic signed [AW-1:0]   prod_tc;
    logic signed [AW-1:0]   acc_base;
    logic signed [AW-1:0]   sum;
    logic signed [AW-1:0]   sum_sat;
    logic signed [AW-1:0]   sum_abs;
    logic                   sat;
    logic [CNT_W-1:0]       cnt_base;
    logic [CNT_W-1:0]       cnt_next;
    logic                   ovr_next;
    logic [N-1:0]           res_sm;

    // The fractional point must lie inside the magnitude field.
    q_in_range: assert property (@(posedge i_clk) Q < N - 1);

    assign beat = i_valid & o_ready;

    always_comb begin
        prod_mag = {2'b00, i_product[MW-1:0]};
        prod_tc  = i_product[N-1] ? -prod_mag : prod_mag;
        // A clear with a simultaneous beat restarts the burst from this beat.
        acc_base = i_clear ? '0 : acc_q;
        cnt_base = i_clear ? '0 : cnt_q;
        // Both operands are bounded by MAX_POS, so AW bits cannot wrap here.
        sum      = acc_base + prod_tc;
        sat      = 1'b0;
        sum_sat  = sum;
        if (sum > MAX_POS) begin
            sum_sat = MAX_POS;
            sat     = 1'b1;
        end else if (sum < MAX_NEG) begin
            sum_sat = MAX_NEG;
            sat     = 1'b1;
        end
        cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
        ovr_next = (ovr_q & ~i_clear) | i_ovr | sat;
        sum_abs  = sum_sat[AW-1] ? -sum_sat : sum_sat;
        res_sm   = {sum_sat[AW-1], MW'(sum_abs)};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StAccum;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_result <= '0;
            o_ovr    <= 1'b0;
            o_count  <= '0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (beat) begin
                        acc_q <= sum_sat;
                        cnt_q <= cnt_next;
                        ovr_q <= ovr_next;
                        if (i_last) begin
                            state_q  <= StHold;
                            o_valid  <= 1'b1;
                            o_ready  <= 1'b0;
                            o_result <= res_sm;
                            o_ovr    <= ovr_next;
                            o_count  <= cnt_next;
                        end
                    end else if (i_clear) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        ovr_q <= 1'b0;
                    end
                end
                StHold: begin
                    // A clear drops the pending result regardless of i_ready.
                    if (i_clear || i_ready) begin
                        state_q <= StAccum;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovr_q   <= 1'b0;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StAccum;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/qmac_accum.md
Name: qmac_accum

Overview:
- Sequential multiply-accumulate back end that sits directly downstream of the combinational sign-magnitude fixed-point multiplier.
- Consumes one product per accepted beat and sums a burst of products terminated by a last flag.
- Presents the saturated sum in the same (N,Q) sign-magnitude format through a valid/ready handshake.
- Used for dot products and filter taps in the robot control datapath.

Parameters:
- Q, 15, fractional bits; must match the upstream multiplier.
- N, 32, total word width: bit N-1 is the sign, bits N-2:0 are the magnitude.
- CNT_W, 8, width of the accepted-term counter.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_clear  input  1  synchronous flush of the running sum, counter and sticky overflow.
- i_valid  input  1  a product is present on i_product.
- o_ready  output  1  block can accept a product.
- i_product  input  N  product in sign-magnitude Q format.
- i_ovr  input  1  upstream multiplier overflow flag for this product.
- i_last  input  1  this beat is the final term of the burst.
- o_valid  output  1  final sum is available.
- i_ready  input  1  downstream accepts the sum.
- o_result  output  N  final sum, sign-magnitude Q format.
- o_ovr  output  1  sticky: any input overflow or any saturation occurred in this burst.
- o_count  output  CNT_W  number of terms in the burst; saturates at 2^CNT_W-1.

Behaviour:
- Reset: state = ACCUM, accumulator = 0, o_valid = 0, o_ready = 1, o_result = 0, o_ovr = 0, o_count = 0. Reset mid-burst or mid-HOLD discards everything.
- States:
  - ACCUM: o_ready = 1. A beat is accepted when i_valid & o_ready.
  - HOLD: o_ready = 0, o_valid = 1.
- Arithmetic:
  - Each accepted product is converted to two's complement. Magnitude 0 with sign 1 is treated as +0.
  - The product is added into an (N+1)-bit accumulator.
  - The result is clamped symmetrically to ±(2^(N-1)-1).
  - Clamping sets sticky overflow. An accepted beat with i_ovr = 1 also sets sticky overflow.
  - Saturation is applied on every step, not only at the end.
- Beat without i_last: the accumulator and count update on the next edge and the state stays ACCUM.
- Beat with i_last:
  - On the next edge, state goes to HOLD and o_valid rises (1-cycle latency from the last beat).
  - o_result gets the sign-magnitude conversion of the final sum. A zero sum is always 0x0.
  - o_ovr and o_count reflect the whole burst, including the last beat.
- HOLD:
  - o_result, o_ovr and o_count stay stable while i_ready = 0.
  - On o_valid & i_ready: accumulator, count and sticky overflow clear, state goes to ACCUM, and o_ready is 1 on the following cycle.
  - There is no zero-bubble turnaround.
- i_clear in ACCUM:
  - Without a simultaneous beat: the accumulator, count and sticky overflow clear.
  - With a simultaneous accepted beat: clear wins for prior state. The accumulator takes that beat's product, count = 1, and sticky overflow = that beat's i_ovr. If i_last is also set, the block enters HOLD with that single term.
- i_clear in HOLD: the pending result is dropped, o_valid = 0 next cycle, the block returns to ACCUM cleared, and i_ready is ignored.
- A burst with no beats never produces o_valid.
- Input changes while o_ready = 0 are ignored.

Test Plan:
- Reset, then beats 0x00008000, 0x00004000, 0x80002000 (last) -> one cycle later o_valid = 1, o_result = 0x0000A000, o_count = 3, o_ovr = 0.
- Beats 0x00008000, 0x80008000 (last) -> o_result = 0x00000000 (never 0x80000000), o_ovr = 0.
- Saturation:
  - Beats 0x7FFFFFFF, 0x00008000 (last) -> o_result = 0x7FFFFFFF, o_ovr = 1.
  - Beats 0xFFFFFFFF, 0x80000001 (last) -> o_result = 0xFFFFFFFF, o_ovr = 1.
- Backpressure: complete burst 0x80008000, 0x80008000 (last); hold i_ready = 0 for 3 cycles -> o_valid stays 1, o_result = 0x80010000 stable, o_ready = 0, extra i_valid beats are ignored; i_ready = 1 -> o_valid = 0 and o_ready = 1 on the next cycle.
- Clear and overflow flag:
  - After beat 0x00010000, assert i_clear with beat 0x00004000 (last) -> o_result = 0x00004000, o_count = 1.
  - A separate beat with i_ovr = 1 -> o_ovr = 1 even when no saturation occurs.
- Assert i_rst during HOLD and during mid-burst -> all outputs return to reset values the next cycle; a new burst 0x00008000 (last) gives o_result = 0x00008000.
